// File: rtl/afifo_pkg.sv
// Shared types for the FIFO write-side arbiter: data word, FIFO depth and arbiter states.
package afifo_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 16;

    typedef logic [DATA_W-1:0] data_ty;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO handshake bundle; master is the arbiter side, slave the requesters plus FIFO.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    import afifo_pkg::*;

    logic   [NUM_REQ-1:0] req_valid;
    data_ty [NUM_REQ-1:0] req_data;
    logic   [NUM_REQ-1:0] req_last;
    logic   [NUM_REQ-1:0] req_ready;
    logic   [NUM_REQ-1:0] gnt;
    logic                 fifo_full;
    logic                 fifo_push;
    data_ty               fifo_data;
    logic                 busy;

    modport master (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, gnt, fifo_push, fifo_data, busy
    );

    modport slave (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, gnt, fifo_push, fifo_data, busy
    );

endinterface

// File: rtl/rr_picker.sv
// Rotating-priority search: first set request at or above ptr_i, wrapping past the top index.
module rr_picker #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic               any_o
);

    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            automatic logic [PTR_W:0] idx;
            idx = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (idx >= (PTR_W+1)'(NUM_REQ)) begin
                idx = idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!any_o && req_i[idx[PTR_W-1:0]]) begin
                pick_o[idx[PTR_W-1:0]] = 1'b1;
                any_o                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one FIFO write port from NUM_REQ requesters.
module fifo_wr_arbiter
    import afifo_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    fifo_wr_arbiter_if.master  bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PTR_W-1:0]   g_idx;
    logic [NUM_REQ-1:0] pick;
    logic               any_req;
    logic               xfer;
    logic               beat;
    logic               burst_end;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i  (bus.req_valid),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .any_o  (any_req)
    );

    // Index of the one-hot grant
    always_comb begin
        g_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                g_idx = PTR_W'(i);
            end
        end
    end

    assign xfer      = (state_q == XFER);
    assign beat      = xfer && bus.req_valid[g_idx] && !bus.fifo_full;
    assign burst_end = beat && (bus.req_last[g_idx] ||
                                (cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST));

    // Zero-latency datapath from the granted requester; all quiet outside XFER
    assign bus.req_ready = xfer ? (gnt_q & {NUM_REQ{~bus.fifo_full}}) : '0;
    assign bus.fifo_push = beat;
    assign bus.fifo_data = xfer ? bus.req_data[g_idx] : '0;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = xfer;

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (any_req) begin
                    gnt_d   = pick;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (burst_end) begin
                    gnt_d    = '0;
                    cnt_d    = '0;
                    rr_ptr_d = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
                    state_d  = IDLE;
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: transaction-level arbiter model, FIFO model and data-order scoreboard.
module tb_fifo_wr_arbiter;
    import afifo_pkg::*;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned MAX_BURST = 4;

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b0;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
        .wr_clk (wr_clk),
        .wr_rst (wr_rst),
        .bus    (bus)
    );

    always #5 wr_clk = ~wr_clk;

    int total = 0;
    int bad   = 0;

    // Requester behaviour and scoreboard state
    bit active [NUM_REQ];
    int seq    [NUM_REQ];
    int left   [NUM_REQ];
    int blen   [NUM_REQ];
    int beat   [NUM_REQ];
    int acc    [NUM_REQ];
    int rx_seq [NUM_REQ];

    bit     force_full, auto_pop, pop_once;
    data_ty fifo_q[$];

    // Arbiter model: current owner (-1 none), beats in this burst, where the next search starts
    int owner, mbeats, next_start;
    int grant_log[$];
    int gpush[$];
    int push_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            bus.req_valid[i] = active[i] && (left[i] > 0);
            bus.req_data[i]  = data_ty'((i << 12) | (seq[i] & 'hfff));
            bus.req_last[i]  = (blen[i] != 0) && (beat[i] == blen[i] - 1);
        end
        bus.fifo_full = force_full || (fifo_q.size() >= int'(FIFO_DEPTH));
    endtask

    task automatic model_reset();
        owner = -1; mbeats = 0; next_start = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            active[i] = 1'b0; beat[i] = 0; acc[i] = 0; left[i] = 0; blen[i] = 0;
        end
        grant_log.delete(); gpush.delete(); fifo_q.delete();
        force_full = 1'b0; pop_once = 1'b0; push_cnt = 0;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_gnt"},   32'(bus.gnt),       32'h0);
        chk({tag, "_push"},  32'(bus.fifo_push), 32'h0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
        chk({tag, "_busy"},  32'(bus.busy),      32'h0);
        chk({tag, "_data"},  32'(bus.fifo_data), 32'h0);
    endtask

    // Per-cycle compare against the model, then advance bench state across the coming edge
    task automatic compare_update();
        logic [NUM_REQ-1:0] eg, er;
        logic ep, eb, full, do_pop, found;
        int id;
        full = bus.fifo_full;
        if (owner < 0) begin
            eg = '0; er = '0; ep = 1'b0; eb = 1'b0;
        end else begin
            eg = NUM_REQ'(1) << owner;
            er = full ? '0 : eg;
            ep = bus.req_valid[owner] && !full;
            eb = 1'b1;
        end
        chk("gnt",       32'(bus.gnt),       32'(eg));
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("fifo_push", 32'(bus.fifo_push), 32'(ep));
        chk("busy",      32'(bus.busy),      32'(eb));
        chk("no_ovf",    32'(bus.fifo_push && full), 32'h0);
        if (owner >= 0) chk("fifo_data", 32'(bus.fifo_data), 32'(bus.req_data[owner]));

        do_pop = (auto_pop || pop_once) && (fifo_q.size() > 0);
        if (bus.fifo_push === 1'b1) begin
            id = int'(bus.fifo_data[15:12]);
            if (id < int'(NUM_REQ)) begin
                chk("sb_order", 32'(bus.fifo_data[11:0]), 32'(rx_seq[id] & 'hfff));
                rx_seq[id]++;
            end else begin
                chk("sb_id", 32'(id), 32'(owner));
            end
            fifo_q.push_back(bus.fifo_data);
            push_cnt++;
        end
        if (do_pop) void'(fifo_q.pop_front());

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (bus.req_valid[i] && bus.req_ready[i]) begin
                seq[i]++; left[i]--; acc[i]++;
                beat[i] = bus.req_last[i] ? 0 : beat[i] + 1;
            end
        end

        if (owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                int idx;
                idx = (next_start + k) % int'(NUM_REQ);
                if (!found && bus.req_valid[idx]) begin
                    found = 1'b1;
                    owner = idx;
                end
            end
            if (found) begin
                grant_log.push_back(owner);
                gpush.push_back(0);
            end
        end else if (ep) begin
            mbeats++;
            gpush[gpush.size()-1]++;
            if (bus.req_last[owner] || mbeats == int'(MAX_BURST)) begin
                next_start = (owner + 1) % int'(NUM_REQ);
                owner      = -1;
                mbeats     = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge wr_clk);
        drive();
        #2;
        compare_update();
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        wr_rst = 1'b0;
        #1;
        check_quiet("rst");
        model_reset();
        drive();
        @(negedge wr_clk);
        wr_rst = 1'b1;
    endtask

    int n, p0;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.fifo_full = 1'b0;
        auto_pop = 1'b1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin seq[i] = 0; rx_seq[i] = 0; end
        model_reset();

        // Single requester, 3-beat burst
        do_reset();
        active[0] = 1; left[0] = 3; blen[0] = 3;
        step();
        chk("s1_gnt_wait", 32'(bus.gnt), 32'h0);
        step();
        chk("s1_gnt", 32'(bus.gnt), 32'h1);
        repeat (6) step();
        chk("s1_pushes", 32'(push_cnt), 32'd3);
        chk("s1_idle", 32'(bus.busy), 32'h0);
        chk("s1_grants", 32'(grant_log.size()), 32'd1);

        // Four continuous requesters, no last: MAX_BURST bursts in rotation
        do_reset();
        for (int i = 0; i < int'(NUM_REQ); i++) begin active[i] = 1; left[i] = 20; blen[i] = 0; end
        repeat (25) step();
        for (int i = 0; i < int'(NUM_REQ); i++) active[i] = 0;
        repeat (3) step();
        chk("s2_ngrants", 32'(grant_log.size()), 32'd5);
        if (grant_log.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("s2_order", 32'(grant_log[k]), 32'(exp_order[k]));
                chk("s2_beats", 32'(gpush[k]), 32'd4);
            end
        end
        chk("s2_pushes", 32'(push_cnt), 32'd20);

        // Full stall mid-burst on requester 2
        do_reset();
        active[2] = 1; left[2] = 4; blen[2] = 4;
        n = 0;
        while (acc[2] < 2 && n < 20) begin step(); n++; end
        chk("s3_reach_beat2", 32'(acc[2]), 32'd2);
        force_full = 1'b1;
        p0 = push_cnt;
        repeat (5) step();
        chk("s3_gnt_hold", 32'(bus.gnt), 32'h4);
        chk("s3_no_push", 32'(push_cnt - p0), 32'd0);
        force_full = 1'b0;
        repeat (6) step();
        chk("s3_beats", 32'(acc[2]), 32'd4);
        chk("s3_pushes", 32'(push_cnt), 32'd4);
        chk("s3_grants", 32'(grant_log.size()), 32'd1);

        // Fill the FIFO, hold at full, then pop exactly one word
        do_reset();
        auto_pop = 1'b0;
        active[0] = 1; left[0] = 40; blen[0] = 0;
        n = 0;
        while (fifo_q.size() < int'(FIFO_DEPTH) && n < 60) begin step(); n++; end
        chk("s4_fill", 32'(fifo_q.size()), 32'd16);
        p0 = push_cnt;
        repeat (5) step();
        chk("s4_full", 32'(bus.fifo_full), 32'h1);
        chk("s4_no_push", 32'(push_cnt - p0), 32'd0);
        pop_once = 1'b1;
        step();
        pop_once = 1'b0;
        p0 = push_cnt;
        repeat (5) step();
        chk("s4_one_push", 32'(push_cnt - p0), 32'd1);
        chk("s4_total", 32'(push_cnt), 32'd17);
        auto_pop = 1'b1;

        // Asynchronous reset during beat 2 of requester 1
        do_reset();
        active[1] = 1; left[1] = 4; blen[1] = 4;
        n = 0;
        while (acc[1] < 1 && n < 20) begin step(); n++; end
        chk("s5_reach_beat1", 32'(acc[1]), 32'd1);
        @(negedge wr_clk);
        drive();
        #2;
        chk("s5_beat2_gnt", 32'(bus.gnt), 32'h2);
        chk("s5_beat2_push", 32'(bus.fifo_push), 32'h1);
        wr_rst = 1'b0;
        #1;
        check_quiet("s5_async");
        model_reset();
        drive();
        @(negedge wr_clk);
        active[1] = 1; left[1] = 4; blen[1] = 4;
        active[3] = 1; left[3] = 4; blen[3] = 4;
        wr_rst = 1'b1;
        repeat (12) step();
        chk("s5_ngrants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            chk("s5_first", 32'(grant_log[0]), 32'd1);
            chk("s5_second", 32'(grant_log[1]), 32'd3);
        end
        chk("s5_pushes", 32'(push_cnt), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-003 SHALL have port wr_clk  input  1  write-domain clock; all state on rising edge.
REQ-004 SHALL have port wr_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester data valid.
REQ-006 SHALL have port req_data  input  NUM_REQ x data_ty  per-requester data, packed array.
REQ-007 SHALL have port req_last  input  NUM_REQ  marks final beat of a requester's burst.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester beat accepted this cycle.
REQ-009 SHALL have port gnt  output  NUM_REQ  one-hot registered grant.
REQ-010 SHALL have port fifo_full  input  1  FIFO write-side full flag.
REQ-011 SHALL have port fifo_push  output  1  FIFO write enable.
REQ-012 SHALL have port fifo_data  output  data_ty  FIFO write data.
REQ-013 SHALL have port busy  output  1  high while state is XFER.

Function
REQ-014 SHALL implement FSM with states IDLE and XFER only.
REQ-015 IDLE: if any req_valid set, SHALL select first set bit searching upward from rr_ptr with wrap-around, register one-hot gnt, go to XFER next edge; else stay IDLE, gnt = 0.
REQ-016 Grant latency SHALL be exactly 1 cycle from req_valid sampled in IDLE to gnt high.
REQ-017 XFER: req_ready[g] SHALL equal !fifo_full for granted index g; all other req_ready bits 0.
REQ-018 XFER: fifo_push SHALL equal req_valid[g] & !fifo_full, combinational, zero latency; fifo_data SHALL equal req_data[g] (don't-care value when fifo_push low is forbidden; drive req_data[g] regardless).
REQ-019 A beat SHALL transfer only when req_valid[g] & req_ready[g]; beat counter (width clog2(MAX_BURST)+1) increments per beat.
REQ-020 Burst SHALL end on the transferring beat with req_last[g] set or with counter reaching MAX_BURST, whichever first.
REQ-021 At burst end SHALL clear gnt, clear counter, set rr_ptr = (g+1) mod NUM_REQ, return to IDLE; one idle bubble cycle between bursts is required.
REQ-022 fifo_full high mid-burst SHALL stall: no push, counter and gnt hold; transfer resumes on the first cycle full is low.
REQ-023 req_valid[g] low while granted SHALL hold grant indefinitely (no timeout); requesters are responsible for completing bursts.
REQ-024 req_valid/req_last of non-granted requesters SHALL be ignored in XFER.
REQ-025 fifo_push SHALL never assert while fifo_full is high (no overflow under any input).

Reset
REQ-026 wr_rst low SHALL asynchronously force state IDLE, gnt = 0, rr_ptr = 0, counter = 0.
REQ-027 During reset SHALL drive fifo_push = 0, req_ready = 0, busy = 0, fifo_data = 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst; after release arbitration restarts from requester 0.

Structure
REQ-029 afifo_pkg SHALL hold data_ty, FIFO_DEPTH (16), and the arbiter state enum (IDLE, XFER).
REQ-030 Rotating priority search SHALL be a combinational sub-module rr_picker (inputs request vector, rr_ptr; outputs one-hot pick, any flag).
REQ-031 gnt, rr_ptr, counter, state SHALL be the only registers.

Verification
REQ-032 Single requester 0 sends 3 beats (last on 3rd), full=0 -> gnt=0001 one cycle after valid, 3 pushes on consecutive cycles, IDLE next.
REQ-033 All 4 requesters valid continuously, no last, MAX_BURST=4 -> grant order 0,1,2,3,0; 4 pushes per grant; 1 bubble between grants.
REQ-034 Requester 2 bursting, fifo_full high for 5 cycles after beat 2 -> no push during full, beats 3-4 pushed after full drops, total 4 beats.
REQ-035 Push 16 words with FIFO depth 16, then keep valid -> full asserts, fifo_push stays 0; pop one word -> exactly one further push.
REQ-036 Assert wr_rst low during beat 2 of requester 1 -> gnt=0, fifo_push=0 immediately (async); after release with requesters 1,3 valid -> requester 1 granted first (rr_ptr=0).
REQ-037 Scoreboard SHALL check fifo data order against per-requester sent sequences across all scenarios, zero mismatches.
